// File: rtl/sky_regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for the skylark XU.
// Reads are combinational; writes, reserves and flushes take effect on the rising edge.
module sky_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  // Returns {hit, data} for register r; later ports overwrite earlier ones,
  // so the highest-index enabled port wins an address conflict.
  function automatic logic [XLEN:0] pick_write(
    input logic [NWR-1:0]      en,
    input logic [NWR*AW-1:0]   addr,
    input logic [NWR*XLEN-1:0] data,
    input logic [AW-1:0]       r
  );
    logic [XLEN:0] res;
    res = '0;
    for (int w = 0; w < NWR; w++) begin
      if (en[w] && (addr[w*AW +: AW] == r)) begin
        res = {1'b1, data[w*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [XLEN-1:0]  wr_win   [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] busy_reg;

  // Register 0 is hard-wired: never written, never busy, never bypassed.
  assign regs_reg[0] = '0;
  assign busy_reg[0] = 1'b0;
  assign wr_hit[0]   = 1'b0;
  assign wr_win[0]   = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic             set_next;
      logic             busy_next;

      assign {wr_hit[gi], wr_win[gi]} = pick_write(wr_en, wr_addr, wr_data, AW'(gi));
      assign set_next = rsv_en && (rsv_addr == AW'(gi));

      // A new reservation outranks a same-cycle writeback: the new producer is still pending.
      assign busy_next = flush    ? 1'b0 :
                         set_next ? 1'b1 :
                         wr_hit[gi] ? 1'b0 : busy_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_reg[gi] <= '0;
          busy_reg[gi] <= 1'b0;
        end else begin
          if (wr_hit[gi]) begin
            regs_reg[gi] <= wr_win[gi];
          end
          busy_reg[gi] <= busy_next;
        end
      end
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          fwd;

      assign addr = rd_addr[gi*AW +: AW];
      assign fwd  = (BYPASS != 0) && wr_hit[addr];
      assign rd_data[gi*XLEN +: XLEN] = fwd ? wr_win[addr] : regs_reg[addr];
      assign rd_busy[gi] = busy_reg[addr] && !fwd;
    end
  endgenerate

  assign busy_vec = busy_reg;

endmodule

// File: tb/tb_sky_regfile_sb.sv
// Directed bench for sky_regfile_sb: one bypassing and one non-bypassing instance
// share the same stimulus; outputs are checked before each rising edge.
module tb_sky_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        flush;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [15:0] busy_vec_b, busy_vec_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sky_regfile_sb #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_b)
  );

  sky_regfile_sb #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_n)
  );

  typedef struct {
    logic [1:0]  we;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        re;
    logic [3:0]  ra;
    logic        fl;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] e0;   // bypass instance expectations
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [15:0] ev;
    logic [31:0] n0;   // non-bypass instance expectations
    logic [31:0] n1;
    logic [1:0]  nb;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] eb, input logic [15:0] ev);
    chk({tag, " rd0_b"}, rd_data_b[31:0], e0);
    chk({tag, " rd1_b"}, rd_data_b[63:32], e1);
    chk({tag, " busy_b"}, {30'd0, rd_busy_b}, {30'd0, eb});
    chk({tag, " vec_b"}, {16'd0, busy_vec_b}, {16'd0, ev});
    chk({tag, " rd0_n"}, rd_data_n[31:0], e0);
    chk({tag, " rd1_n"}, rd_data_n[63:32], e1);
    chk({tag, " vec_n"}, {16'd0, busy_vec_n}, {16'd0, ev});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we     wa0   wd0            wa1   wd1            re    ra    fl    ra0   ra1   e0             e1             eb     ev        n0             n1             nb
    vt[0]  = '{2'b01, 4'd0, 32'hDEADBEEF, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 32'h0,        32'h0,        2'b00, 16'h0000, 32'h0,        32'h0,        2'b00};
    vt[1]  = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h0,        32'h0,        2'b00, 16'h0000, 32'h0,        32'h0,        2'b00};
    vt[2]  = '{2'b01, 4'd5, 32'h12345678, 4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 32'h0,        32'h12345678, 2'b00, 16'h0000, 32'h0,        32'h0,        2'b00};
    vt[3]  = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 32'h12345678, 32'h0,        2'b00, 16'h0000, 32'h12345678, 32'h0,        2'b00};
    vt[4]  = '{2'b11, 4'd7, 32'hAAAA0000, 4'd7, 32'h5555FFFF, 1'b0, 4'd0, 1'b0, 4'd7, 4'd7, 32'h5555FFFF, 32'h5555FFFF, 2'b00, 16'h0000, 32'h0,        32'h0,        2'b00};
    vt[5]  = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd7, 4'd5, 32'h5555FFFF, 32'h12345678, 2'b00, 16'h0000, 32'h5555FFFF, 32'h12345678, 2'b00};
    vt[6]  = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b1, 4'd3, 1'b0, 4'd3, 4'd0, 32'h0,        32'h0,        2'b00, 16'h0000, 32'h0,        32'h0,        2'b00};
    vt[7]  = '{2'b10, 4'd0, 32'h0,        4'd3, 32'h33,       1'b1, 4'd3, 1'b0, 4'd3, 4'd7, 32'h33,       32'h5555FFFF, 2'b00, 16'h0008, 32'h0,        32'h5555FFFF, 2'b01};
    vt[8]  = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd3, 4'd3, 32'h33,       32'h33,       2'b11, 16'h0008, 32'h33,       32'h33,       2'b11};
    vt[9]  = '{2'b01, 4'd3, 32'h44,       4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd3, 4'd5, 32'h44,       32'h12345678, 2'b00, 16'h0008, 32'h33,       32'h12345678, 2'b01};
    vt[10] = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd3, 4'd0, 32'h44,       32'h0,        2'b00, 16'h0000, 32'h44,       32'h0,        2'b00};
    vt[11] = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b1, 4'd9, 1'b0, 4'd9, 4'd10, 32'h0,       32'h0,        2'b00, 16'h0000, 32'h0,        32'h0,        2'b00};
    vt[12] = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b1, 4'd10, 1'b0, 4'd9, 4'd10, 32'h0,      32'h0,        2'b01, 16'h0200, 32'h0,        32'h0,        2'b01};
    vt[13] = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b1, 4'd11, 1'b1, 4'd9, 4'd10, 32'h0,      32'h0,        2'b11, 16'h0600, 32'h0,        32'h0,        2'b11};
    vt[14] = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd11, 4'd7, 32'h0,       32'h5555FFFF, 2'b00, 16'h0000, 32'h0,        32'h5555FFFF, 2'b00};
    vt[15] = '{2'b00, 4'd0, 32'h0,        4'd0, 32'h0,        1'b0, 4'd0, 1'b0, 4'd5, 4'd3, 32'h12345678, 32'h44,       2'b00, 16'h0000, 32'h12345678, 32'h44,       2'b00};

    reset = 1'b1;
    rd_addr = '0;
    idle();
    step();
    step();
    chk_all("reset", 32'h0, 32'h0, 2'b00, 16'h0000);
    reset = 1'b0;
    #1;

    for (int i = 0; i < NV; i++) begin
      wr_en = vt[i].we;
      wr_addr = {vt[i].wa1, vt[i].wa0};
      wr_data = {vt[i].wd1, vt[i].wd0};
      rsv_en = vt[i].re;
      rsv_addr = vt[i].ra;
      flush = vt[i].fl;
      rd_addr = {vt[i].ra1, vt[i].ra0};
      #1;
      $display("vec %0d: rd_b=%h_%h busy_b=%b vec=%h rd_n=%h_%h busy_n=%b", i,
               rd_data_b[63:32], rd_data_b[31:0], rd_busy_b, busy_vec_b,
               rd_data_n[63:32], rd_data_n[31:0], rd_busy_n);
      chk($sformatf("v%0d rd0_b", i), rd_data_b[31:0], vt[i].e0);
      chk($sformatf("v%0d rd1_b", i), rd_data_b[63:32], vt[i].e1);
      chk($sformatf("v%0d busy_b", i), {30'd0, rd_busy_b}, {30'd0, vt[i].eb});
      chk($sformatf("v%0d vec_b", i), {16'd0, busy_vec_b}, {16'd0, vt[i].ev});
      chk($sformatf("v%0d rd0_n", i), rd_data_n[31:0], vt[i].n0);
      chk($sformatf("v%0d rd1_n", i), rd_data_n[63:32], vt[i].n1);
      chk($sformatf("v%0d busy_n", i), {30'd0, rd_busy_n}, {30'd0, vt[i].nb});
      chk($sformatf("v%0d vec_n", i), {16'd0, busy_vec_n}, {16'd0, vt[i].ev});
      step();
    end

    // r4 = 1 and busy, then an asynchronous reset between edges
    idle();
    wr_en = 2'b01; wr_addr = {4'd0, 4'd4}; wr_data = {32'h0, 32'h1};
    rsv_en = 1'b1; rsv_addr = 4'd4;
    rd_addr = {4'd0, 4'd4};
    step();
    idle();
    #1;
    $display("async: r4_b=%h r4_n=%h vec=%h", rd_data_b[31:0], rd_data_n[31:0], busy_vec_b);
    chk_all("pre_async", 32'h1, 32'h0, 2'b01, 16'h0010);
    #1;
    reset = 1'b1;
    #1;
    $display("async reset: r4_b=%h vec=%h", rd_data_b[31:0], busy_vec_b);
    chk_all("async", 32'h0, 32'h0, 2'b00, 16'h0000);

    // reset held across an edge overrides a same-cycle write and reserve
    wr_en = 2'b11; wr_addr = {4'd6, 4'd4}; wr_data = {32'h66, 32'h99};
    rsv_en = 1'b1; rsv_addr = 4'd4;
    step();
    idle();
    rd_addr = {4'd6, 4'd4};
    #1;
    $display("reset hold: r4_b=%h r6_b=%h vec=%h", rd_data_b[31:0], rd_data_b[63:32], busy_vec_b);
    chk_all("rst_hold", 32'h0, 32'h0, 2'b00, 16'h0000);
    reset = 1'b0;
    #1;
    chk_all("rst_rel", 32'h0, 32'h0, 2'b00, 16'h0000);

    // normal operation resumes after release
    wr_en = 2'b10; wr_addr = {4'd6, 4'd0}; wr_data = {32'hBEEF, 32'h0};
    step();
    idle();
    #1;
    $display("post reset: r6_b=%h r6_n=%h", rd_data_b[63:32], rd_data_n[63:32]);
    chk_all("post_rst", 32'h0, 32'hBEEF, 2'b00, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sky_regfile_sb.md
# sky_regfile_sb

Parametrised multi-port register file with an integrated scoreboard for the skylark XU. It provides NRD combinational read ports and NWR synchronous write ports, with optional write-to-read bypass. A per-register busy bit is set when an instruction issues to a destination and cleared when that destination is written back. The XU issue stage uses this block to detect RAW hazards on multi-cycle results.

## Interface
- XLEN, 32: register width in bits
- NREGS, 16: number of registers (power of two, >= 2); AW = $clog2(NREGS)
- NRD, 2: number of read ports
- NWR, 2: number of write ports
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- rd_addr  input  NRD*AW  read addresses, port p at bits [p*AW +: AW]
- rd_data  output  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
- rd_busy  output  NRD  scoreboard busy flag for each read address
- wr_en  input  NWR  write enables
- wr_addr  input  NWR*AW  write addresses
- wr_data  input  NWR*XLEN  write data
- rsv_en  input  1  reserve destination (sets busy) at issue
- rsv_addr  input  AW  destination to reserve
- flush  input  1  synchronous clear of all busy bits; register contents kept
- busy_vec  output  NREGS  raw busy bits, for debug and the issue stage

## Operation
- Register 0 reads as 0. Writes to register 0 are dropped. busy[0] is never set; a reserve to register 0 is ignored.
- Write: on a rising edge with wr_en[w]=1 and wr_addr[w]!=0, reg[wr_addr[w]] <= wr_data[w].
- Write conflict: if several enabled ports target the same address, the highest-index port wins, for both data and bypass.
- Read is combinational: rd_data[p] = reg[rd_addr[p]], or 0 for address 0.
- Bypass (BYPASS=1): if any enabled write port targets rd_addr[p] (address != 0), rd_data[p] returns the winning wr_data that cycle. With BYPASS=0, new data is visible the cycle after the edge.
- Busy update per edge, for each register r != 0:
  - set = rsv_en & (rsv_addr==r)
  - clr = any wr_en[w] & (wr_addr[w]==r)
  - next busy = flush ? 0 : set ? 1 : clr ? 0 : busy
- Set beats clear: a same-cycle writeback and new issue to r leave r busy, because the new producer is pending.
- flush beats set.
- Reserving an already-busy register keeps it busy; there is no count, so a single writeback clears it.
- rd_busy[p] = busy[rd_addr[p]], except with BYPASS=1 it is 0 when a same-cycle write hits rd_addr[p] (the data is being forwarded). rd_busy for address 0 is always 0.
- A write to a non-busy register is legal; it updates data and leaves busy at 0.

## Timing
- Reset (asynchronous, immediate): all registers 0, all busy bits 0. Hence rd_data=0, rd_busy=0, busy_vec=0 while reset is high and after release until written.
- Reset asserted mid-operation overrides any same-cycle write, reserve or flush.
- Write latency is 1 edge. Read latency is 0 (combinational from rd_addr, and from wr_* when BYPASS=1).
- Reserve-to-busy latency is 1 edge. Writeback-to-not-busy latency is 1 edge, or 0 on rd_busy via bypass.
- No handshakes. Every enable is sampled every cycle.

## Test plan
- Reset, then read all addresses -> rd_data=0, busy_vec=0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- BYPASS=1: write 0x12345678 to r5 on port 0 while port 1 reads r5 -> rd_data=0x12345678 that cycle. Repeat with BYPASS=0 -> old value that cycle, new value next cycle.
- Both write ports target r7 with 0xAAAA0000 and 0x5555FFFF -> r7=0x5555FFFF, and the bypass returns 0x5555FFFF.
- rsv r3 -> busy_vec[3]=1 next cycle, rd_busy=1 when reading r3. Write r3 with rsv r3 in the same cycle -> still busy. Write r3 alone -> busy clears.
- rsv r9 and r10, then flush asserted with rsv r11 -> busy_vec=0 and register data unchanged.
- Assert reset asynchronously between edges while r4=0x1 and r4 busy -> r4 reads 0 and busy_vec=0 immediately, without waiting for a clock edge.
